// File: rtl/sr_mem_arb_pkg.sv
// Shared definitions for the sr_mem data-memory arbiter: size codes, FSM states
// and the alignment check.
package sr_mem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Size 11 is illegal; halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic acc_bad(input logic [1:0] size, input logic [1:0] a);
        return (size == 2'b11) || ((size == SZ_H) && a[0]) ||
               ((size == SZ_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin arbiter. rr_last remembers the most recent winner and
// resets to 1 so requester 0 wins the first tie.
module sr_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_last_q, rr_last_d;

    always_comb begin
        gnt       = '0;
        rr_last_d = rr_last_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
        if (gnt != '0) rr_last_d = gnt[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_last_q <= 1'b1;
        else        rr_last_q <= rr_last_d;
    end

endmodule

// File: rtl/sr_mem_arb.sv
// Shares one sr_mem data memory between the core LSU (m0) and a debug/loader
// port (m1); each access takes WAIT_CYCLES+1 memory cycles.
module sr_mem_arb
    import sr_mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned AW          = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m0_we,
    input  logic [1:0]    m0_size,
    input  logic          m0_sign,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_we,
    input  logic [1:0]    m1_size,
    input  logic          m1_sign,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    output logic          mem_sign,
    output logic          mem_byte_w,
    output logic          mem_half_w,
    output logic          mem_word_w,
    input  logic [31:0]   mem_rdata
);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic          owner_q, owner_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [1:0]    err_q, err_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
    logic [1:0]    gnt;
    logic          sel;

    sr_rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({m1_req, m0_req}),
        .en    (state_q == ST_IDLE),
        .gnt   (gnt)
    );

    assign sel       = gnt[1];
    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        size_d   = size_q;
        sign_d   = sign_q;
        owner_d  = owner_q;
        rvalid_d = '0;
        err_d    = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != '0) begin
                    addr_d  = sel ? m1_addr  : m0_addr;
                    wdata_d = sel ? m1_wdata : m0_wdata;
                    we_d    = sel ? m1_we    : m0_we;
                    size_d  = sel ? m1_size  : m0_size;
                    sign_d  = sel ? m1_sign  : m0_sign;
                    owner_d = sel;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = acc_bad(size_d, addr_d[1:0]) ? ST_ERR : ST_ACC;
                end
            end
            ST_ACC: begin
                if (cnt_q == '0) begin
                    rvalid_d[owner_q] = 1'b1;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = mem_rdata;
                        else         rdata0_d = mem_rdata;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR: begin
                rvalid_d[owner_q] = 1'b1;
                err_d[owner_q]    = 1'b1;
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write enable only on the final ACC cycle so a store has a single write edge.
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_sign   = 1'b0;
        mem_byte_w = 1'b0;
        mem_half_w = 1'b0;
        mem_word_w = 1'b0;
        if (state_q == ST_ACC) begin
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
            mem_we     = we_q && (cnt_q == '0);
            mem_sign   = sign_q;
            mem_byte_w = (size_q == SZ_B);
            mem_half_w = (size_q == SZ_H);
            mem_word_w = (size_q == SZ_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            sign_q   <= 1'b0;
            owner_q  <= 1'b0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_sr_mem_arb.sv
// Directed bench for sr_mem_arb: one instance with WAIT_CYCLES=0 and one with 3,
// each attached to a small byte-addressed sr_mem model.
module tb_sr_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_clear;

    logic        rq [2][2];
    logic [31:0] ad [2][2];
    logic [31:0] wd [2][2];
    logic        we [2][2];
    logic [1:0]  sz [2][2];
    logic        sg [2][2];
    logic        gnt[2][2];
    logic        rv [2][2];
    logic [31:0] rd [2][2];
    logic        er [2][2];

    logic [31:0] ma  [2];
    logic [31:0] mwd [2];
    logic        mwe [2];
    logic        msg [2];
    logic        mbw [2];
    logic        mhw [2];
    logic        mww [2];
    logic [31:0] mrd [2];

    logic [7:0]  mem [2][64];

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt [2];
    int rv_cnt [2][2];
    int both_cnt;

    always #5 clk = ~clk;

    sr_mem_arb #(.WAIT_CYCLES(0), .AW(32)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(rq[0][0]), .m0_addr(ad[0][0]), .m0_wdata(wd[0][0]), .m0_we(we[0][0]),
        .m0_size(sz[0][0]), .m0_sign(sg[0][0]), .m0_gnt(gnt[0][0]), .m0_rvalid(rv[0][0]),
        .m0_rdata(rd[0][0]), .m0_err(er[0][0]),
        .m1_req(rq[0][1]), .m1_addr(ad[0][1]), .m1_wdata(wd[0][1]), .m1_we(we[0][1]),
        .m1_size(sz[0][1]), .m1_sign(sg[0][1]), .m1_gnt(gnt[0][1]), .m1_rvalid(rv[0][1]),
        .m1_rdata(rd[0][1]), .m1_err(er[0][1]),
        .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_we(mwe[0]), .mem_sign(msg[0]),
        .mem_byte_w(mbw[0]), .mem_half_w(mhw[0]), .mem_word_w(mww[0]), .mem_rdata(mrd[0])
    );

    sr_mem_arb #(.WAIT_CYCLES(3), .AW(32)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(rq[1][0]), .m0_addr(ad[1][0]), .m0_wdata(wd[1][0]), .m0_we(we[1][0]),
        .m0_size(sz[1][0]), .m0_sign(sg[1][0]), .m0_gnt(gnt[1][0]), .m0_rvalid(rv[1][0]),
        .m0_rdata(rd[1][0]), .m0_err(er[1][0]),
        .m1_req(rq[1][1]), .m1_addr(ad[1][1]), .m1_wdata(wd[1][1]), .m1_we(we[1][1]),
        .m1_size(sz[1][1]), .m1_sign(sg[1][1]), .m1_gnt(gnt[1][1]), .m1_rvalid(rv[1][1]),
        .m1_rdata(rd[1][1]), .m1_err(er[1][1]),
        .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_we(mwe[1]), .mem_sign(msg[1]),
        .mem_byte_w(mbw[1]), .mem_half_w(mhw[1]), .mem_word_w(mww[1]), .mem_rdata(mrd[1])
    );

    // sr_mem model: little-endian, synchronous write, combinational read with extension.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 64; i++) mem[k][i] <= 8'h00;
            mem[0][0] <= 8'h44; mem[0][1] <= 8'h33; mem[0][2] <= 8'h22; mem[0][3] <= 8'h11;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mwe[k]) begin
                    mem[k][ma[k][5:0]] <= mwd[k][7:0];
                    if (mhw[k] || mww[k]) mem[k][ma[k][5:0] + 6'd1] <= mwd[k][15:8];
                    if (mww[k]) begin
                        mem[k][ma[k][5:0] + 6'd2] <= mwd[k][23:16];
                        mem[k][ma[k][5:0] + 6'd3] <= mwd[k][31:24];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            logic [5:0] a;
            a = ma[k][5:0];
            if (mww[k])
                mrd[k] = {mem[k][a + 6'd3], mem[k][a + 6'd2], mem[k][a + 6'd1], mem[k][a]};
            else if (mhw[k])
                mrd[k] = {{16{msg[k] & mem[k][a + 6'd1][7]}}, mem[k][a + 6'd1], mem[k][a]};
            else if (mbw[k])
                mrd[k] = {{24{msg[k] & mem[k][a][7]}}, mem[k][a]};
            else
                mrd[k] = '0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mwe[k]) we_cnt[k]++;
            if (rv[k][0]) rv_cnt[k][0]++;
            if (rv[k][1]) rv_cnt[k][1]++;
            if (gnt[k][0] && gnt[k][1]) both_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access: wait for gnt, drop req, scramble inputs, then measure latency to rvalid.
    task automatic do_access(input int k, input int m, input logic w, input logic [1:0] s,
                             input logic sx, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic exp_err,
                             input int exp_lat, input string tag);
        int n;
        int we0;
        rq[k][m] = 1'b1; ad[k][m] = a; wd[k][m] = d; we[k][m] = w; sz[k][m] = s; sg[k][m] = sx;
        #1;
        n = 0;
        while (gnt[k][m] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_val({tag, "_gnt"}, 32'(gnt[k][m]), 32'd1);
        we0 = we_cnt[k];
        step();
        rq[k][m] = 1'b0; ad[k][m] = 32'hFFFF_FFFC; wd[k][m] = '1; we[k][m] = ~w; sg[k][m] = ~sx;
        n = 1;
        while (rv[k][m] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_val({tag, "_err"}, 32'(er[k][m]), 32'(exp_err));
        check_val({tag, "_rdata"}, rd[k][m], exp_rd);
        step();
        check_val({tag, "_wecnt"}, 32'(we_cnt[k] - we0), (w && !exp_err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int r0, r1, ng, n, t_rv, t_g, we0;
        int seq [6];

        rst_n = 1'b0;
        mem_clear = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < 2; m++) begin
                rq[k][m] = 1'b0; ad[k][m] = '0; wd[k][m] = '0;
                we[k][m] = 1'b0; sz[k][m] = '0; sg[k][m] = 1'b0;
            end
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rdata0", rd[0][0], 32'h0);
        check_val("rst_rdata1", rd[1][1], 32'h0);
        check_val("rst_rvalid", {28'h0, rv[0][0], rv[0][1], rv[1][0], rv[1][1]}, 32'h0);
        check_val("rst_mem", {25'h0, mwe[0], mbw[0], mhw[0], mww[0], mwe[1], mbw[1], mww[1]}, 32'h0);
        mem_clear = 1'b0;
        rst_n = 1'b1;
        step();

        // Word store/load round trip, WAIT=0
        do_access(0, 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, "t1_sw");
        do_access(0, 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "t1_lw");

        // Byte store and sign/zero-extended loads from m1
        do_access(0, 1, 1'b1, 2'b00, 1'b0, 32'h4, 32'hABCD_EFFE, 32'h0, 1'b0, 2, "t2_sb");
        do_access(0, 1, 1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'hFFFF_FFFE, 1'b0, 2, "t2_lbs");
        do_access(0, 1, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'h0000_00FE, 1'b0, 2, "t2_lbu");
        do_access(0, 1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0000_00FE, 1'b0, 2, "t2_lw");

        // Both requesting continuously: grants alternate starting with m0
        r0 = rv_cnt[0][0]; r1 = rv_cnt[0][1];
        rq[0][0] = 1'b1; ad[0][0] = 32'h10; we[0][0] = 1'b0; sz[0][0] = 2'b10; sg[0][0] = 1'b0;
        rq[0][1] = 1'b1; ad[0][1] = 32'h4;  we[0][1] = 1'b0; sz[0][1] = 2'b00; sg[0][1] = 1'b0;
        #1;
        ng = 0;
        n = 0;
        while (ng < 6 && n < 40) begin
            if (gnt[0][0] === 1'b1) begin seq[ng] = 0; ng++; end
            else if (gnt[0][1] === 1'b1) begin seq[ng] = 1; ng++; end
            if (ng == 6) break;
            step();
            n++;
        end
        step();
        rq[0][0] = 1'b0; rq[0][1] = 1'b0;
        repeat (5) step();
        check_val("t3_ngrants", 32'(ng), 32'd6);
        for (int i = 0; i < 6; i++) check_val($sformatf("t3_order%0d", i), 32'(seq[i]), 32'(i % 2));
        check_val("t3_rv_m0", 32'(rv_cnt[0][0] - r0), 32'd3);
        check_val("t3_rv_m1", 32'(rv_cnt[0][1] - r1), 32'd3);
        check_val("t3_both_gnt", 32'(both_cnt), 32'd0);
        check_val("t3_rdata0", rd[0][0], 32'hDEAD_BEEF);
        check_val("t3_rdata1", rd[0][1], 32'h0000_00FE);

        // Rejected accesses: misaligned half, misaligned word store, illegal size
        do_access(0, 0, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'hDEAD_BEEF, 1'b1, 2, "t4_lh_mis");
        do_access(0, 1, 1'b1, 2'b10, 1'b0, 32'h12, 32'h5555_5555, 32'h0000_00FE, 1'b1, 2, "t4_sw_mis");
        do_access(0, 1, 1'b1, 2'b11, 1'b0, 32'h0, 32'h7777_7777, 32'h0000_00FE, 1'b1, 2, "t4_sz11");
        do_access(0, 0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1122_3344, 1'b0, 2, "t4_lw0");
        do_access(0, 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "t4_lw10");

        // WAIT=3 half store from m1 with a pending m0 load granted in the rvalid cycle
        we0 = we_cnt[1];
        rq[1][1] = 1'b1; ad[1][1] = 32'h8; wd[1][1] = 32'hFFFF_A5A5; we[1][1] = 1'b1;
        sz[1][1] = 2'b01; sg[1][1] = 1'b0;
        #1;
        check_val("t5_gnt1", 32'(gnt[1][1]), 32'd1);
        step();
        rq[1][1] = 1'b0;
        rq[1][0] = 1'b1; ad[1][0] = 32'h8; we[1][0] = 1'b0; sz[1][0] = 2'b01; sg[1][0] = 1'b0;
        #1;
        t_rv = 0;
        t_g = 0;
        for (int c = 1; c <= 10; c++) begin
            if (rv[1][1] === 1'b1 && t_rv == 0) t_rv = c;
            if (gnt[1][0] === 1'b1 && t_g == 0) t_g = c;
            if (t_g != 0) break;
            step();
        end
        check_val("t5_rv_lat", 32'(t_rv), 32'd5);
        check_val("t5_m0_gnt_cyc", 32'(t_g), 32'd5);
        step();
        rq[1][0] = 1'b0;
        n = 1;
        while (rv[1][0] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check_val("t5_lh_lat", 32'(n), 32'd5);
        check_val("t5_lh_rdata", rd[1][0], 32'h0000_A5A5);
        check_val("t5_wecnt", 32'(we_cnt[1] - we0), 32'd1);
        step();

        // Reset during the ACC phase of a WAIT=3 store
        we0 = we_cnt[1];
        r0 = rv_cnt[1][0];
        rq[1][0] = 1'b1; ad[1][0] = 32'h20; wd[1][0] = 32'h1234_5678; we[1][0] = 1'b1;
        sz[1][0] = 2'b10; sg[1][0] = 1'b0;
        #1;
        n = 0;
        while (gnt[1][0] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_val("t6_gnt", 32'(gnt[1][0]), 32'd1);
        step();
        rq[1][0] = 1'b0;
        step();
        check_val("t6_addr_acc", ma[1], 32'h20);
        rst_n = 1'b0;
        #1;
        check_val("t6_addr_rst", ma[1], 32'h0);
        check_val("t6_ctl_rst", {29'h0, mwe[1], mww[1], rv[1][0]}, 32'h0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();
        check_val("t6_no_rvalid", 32'(rv_cnt[1][0] - r0), 32'd0);
        check_val("t6_no_write", 32'(we_cnt[1] - we0), 32'd0);
        check_val("t6_rdata_rst", rd[1][0], 32'h0);
        do_access(1, 1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 5, "t6_lw20");

        // After reset m0 wins the first tie again
        rq[1][0] = 1'b1; rq[1][1] = 1'b1;
        ad[1][0] = 32'h0; ad[1][1] = 32'h0; sz[1][0] = 2'b10; sz[1][1] = 2'b10;
        we[1][0] = 1'b0; we[1][1] = 1'b0;
        #1;
        check_val("t6_tie_gnt", {30'h0, gnt[1][1], gnt[1][0]}, 32'h1);
        step();
        rq[1][0] = 1'b0; rq[1][1] = 1'b0;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
